idu_hazard_ctrl: RTL and testbench
==================================

# idu_hazard_ctrl

Decode-side hazard and pipeline-control unit that produces the `stall_flag` control bus consumed by the ID→EX pipeline register. It keeps a per-register scoreboard of destinations held by outstanding long-latency operations (loads, mul/div). It stalls decode on RAW/WAW hits or when the outstanding-op budget is exhausted, and issues flushes on execute-stage redirects.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum long-latency ops in flight, range 1–15.

Ports:
- `clk`  in  1: core clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `inst_valid_i`  in  1: decode stage holds a valid instruction.
- `rs1_raddr_i`  in  `REG_ADDR_WIDTH`: rs1 address of the decode instruction.
- `rs1_re_i`  in  1: rs1 is read.
- `rs2_raddr_i`  in  `REG_ADDR_WIDTH`: rs2 address of the decode instruction.
- `rs2_re_i`  in  1: rs2 is read.
- `reg_we_i`  in  1: decode instruction writes a GPR.
- `reg_waddr_i`  in  `REG_ADDR_WIDTH`: decode destination register.
- `is_long_op_i`  in  1: decode instruction is a long-latency op.
- `wb_valid_i`  in  1: a long-latency op writes back this cycle.
- `wb_waddr_i`  in  `REG_ADDR_WIDTH`: writeback destination.
- `jump_flag_i`  in  1: execute-stage redirect (mispredict or jump).
- `ext_stall_i`  in  1: external stall request (e.g. bus busy).
- `stall_flag_o`  out  `CU_BUS_WIDTH`: control bus. Only bits `CU_STALL` and `CU_FLUSH` are driven; all other bits are 0.
- `scoreboard_o`  out  32: pending-register bitmap, debug only.
- `outstanding_o`  out  4: in-flight long-op count.

## Operation
- **Scoreboard** `sb[31:0]` is registered; bit 0 is hard-wired to 0.
- **Issue**: `issue = inst_valid_i & ~stall & ~flush`.
- **Set**: on `issue & reg_we_i & is_long_op_i & (reg_waddr_i != 0)`, set `sb[reg_waddr_i]` at the clock edge.
- **Clear**: on `wb_valid_i`, clear `sb[wb_waddr_i]`.
- **Set and clear of the same bit in one cycle**: set wins. The new owner is the issuing instruction.
- **RAW hit**: `inst_valid_i & ((rs1_re_i & sb[rs1]) | (rs2_re_i & sb[rs2]))`. A source address of x0 never hits.
- **WAW hit**: `inst_valid_i & reg_we_i & sb[reg_waddr_i]`, with `reg_waddr_i` ≠ 0.
- **Counter** `cnt`:
  - +1 on a long-op issue (as defined under Set).
  - −1 on `wb_valid_i`.
  - Simultaneous +1 and −1 leaves it unchanged.
  - It never exceeds `MAX_OUTSTANDING`.
  - `wb_valid_i` with `cnt == 0` is a protocol error: `cnt` stays 0 (saturates), and the scoreboard clear still happens.
- **Full stall**: `inst_valid_i & is_long_op_i & reg_we_i & (cnt == MAX_OUTSTANDING)`.
- **Stall**: `stall = ~flush & (raw | waw | full | ext_stall_i)`.
- **Flush**: `flush = jump_flag_i | flush_q`. `flush_q` is a 1-cycle register loaded with `jump_flag_i`. It kills the wrong-path instruction that enters decode on the cycle after the redirect.
- **Priority**: flush overrides stall. `CU_STALL` is never asserted together with `CU_FLUSH`, because the pipe register only applies a flush when it is not stalled.
- **Flush does not touch the scoreboard or the counter**: already-issued long ops still write back.

## Timing
- `stall_flag_o` is combinational from the current inputs and registered state; it is valid in the same cycle as the decode inputs.
- Scoreboard, counter and `flush_q` update on the rising `clk` edge.
- A producer issued in cycle N causes a RAW stall for a dependent instruction at decode in cycle N+1.
- Reset values:
  - `sb = 0`, `cnt = 0`, `flush_q = 0`.
  - `stall_flag_o = 0` while inputs are idle.
  - `scoreboard_o = 0`, `outstanding_o = 0`.
- Reset asserted mid-operation clears all state immediately (asynchronously). Writebacks for ops issued before reset are ignored; no underflow occurs, because `cnt` saturates at 0.
- `jump_flag_i` held for k consecutive cycles produces a flush for k+1 cycles.

## Configuration
- `HAZARD_WB_BYPASS_EN` defined:
  - A `wb_valid_i` whose `wb_waddr_i` matches a RAW/WAW hit register in the same cycle suppresses that hit, because writeback data is forwarded.
  - `cnt == MAX_OUTSTANDING` together with a same-cycle `wb_valid_i` does not raise the full stall.
- `HAZARD_WB_BYPASS_EN` undefined:
  - Hits are evaluated on registered `sb`/`cnt` only, so a dependent instruction stalls one extra cycle after the writeback.

## Test plan
- **RAW stall**: issue long op x5 at cycle 0 → at cycle 1, decode `rs1=5`, `rs1_re=1` gives `CU_STALL=1`. `wb_valid_i`, `wb_waddr=5` at cycle 3 → `CU_STALL=0` at cycle 3 with bypass, at cycle 4 without.
- **Counter full** (`MAX_OUTSTANDING=4`): issue 4 long ops to x1–x4 → `outstanding_o=4`. A fifth long op to x6 gives `CU_STALL=1` until any `wb_valid_i`.
- **Flush over stall**: RAW hit active and `jump_flag_i=1` for 1 cycle → `CU_FLUSH=1`, `CU_STALL=0` for 2 cycles. `scoreboard_o` unchanged, and no set happens for the flushed instruction.
- **Simultaneous set and clear**: x7 pending; issue a new long op to x7 and `wb_valid_i` for x7 in the same cycle → `sb[7]` stays 1 and `cnt` is unchanged.
- **x0 handling**: long op with `reg_waddr=0` → `sb=0`, `cnt` +1. Decode `rs1=0` never stalls.
- **Reset mid-operation**: 3 ops pending, then pulse `rst_n` low → `scoreboard_o=0` and `outstanding_o=0` immediately. A stray `wb_valid_i` afterwards leaves `cnt=0`.

Source files
------------

// File: rtl/idu_hazard_ctrl.sv
// rtl/idu_hazard_ctrl.sv - decode-side hazard scoreboard and stall/flush control for the ID/EX pipe register
//
// Purpose:
//   Tracks the destination registers of in-flight long-latency ops (loads, mul/div)
//   and stalls decode on RAW/WAW hits against them. It also stalls decode when the
//   in-flight budget is used up or when an external stall is requested. On an
//   execute-stage redirect it raises a flush for the redirect cycle and for the
//   following cycle.
//
// Optional feature macro: HAZARD_WB_BYPASS_EN
//   When defined, a same-cycle writeback to a hit register masks that hit,
//   because the writeback data is forwarded. The same-cycle writeback also masks
//   the budget-full stall.
//
// Parameters:
//   MAX_OUTSTANDING  long ops allowed in flight (1..15)
//   REG_ADDR_WIDTH   GPR address width (fixed at 5, 32 GPRs)
//   CU_BUS_WIDTH     width of the control bus
//   CU_STALL         bit index of the stall line within stall_flag_o
//   CU_FLUSH         bit index of the flush line within stall_flag_o
//
// Ports:
//   clk, rst_n        core clock; asynchronous active-low reset
//   inst_valid_i      decode holds a valid instruction
//   rs1_raddr_i/re_i  rs1 address and read enable
//   rs2_raddr_i/re_i  rs2 address and read enable
//   reg_we_i          decode instruction writes a GPR
//   reg_waddr_i       decode destination register
//   is_long_op_i      decode instruction is long-latency
//   wb_valid_i        a long op writes back this cycle
//   wb_waddr_i        writeback destination register
//   jump_flag_i       execute-stage redirect
//   ext_stall_i       external stall request
//   stall_flag_o      control bus; only CU_STALL / CU_FLUSH are driven
//   scoreboard_o      pending-register bitmap (debug)
//   outstanding_o     in-flight long-op count

module idu_hazard_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int REG_ADDR_WIDTH = 5,
    parameter int CU_BUS_WIDTH    = 4,
    parameter int CU_STALL        = 0,
    parameter int CU_FLUSH        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_raddr_i,
    input  logic                      rs1_re_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_raddr_i,
    input  logic                      rs2_re_i,
    input  logic                      reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                      is_long_op_i,
    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic                      jump_flag_i,
    input  logic                      ext_stall_i,
    output logic [CU_BUS_WIDTH-1:0]   stall_flag_o,
    output logic [31:0]               scoreboard_o,
    output logic [3:0]                outstanding_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [31:0] sb_q;
    logic [31:0] sb_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        flush_q;

    logic rs1_hit;
    logic rs2_hit;
    logic waw;
    logic raw;
    logic full;
    logic stall;
    logic flush;
    logic issue;
    logic long_issue;
    logic sb_set;
    logic cnt_inc;
    logic cnt_dec;

`ifdef HAZARD_WB_BYPASS_EN
    // A writeback landing this cycle is forwarded, so it cannot be a hazard.
    logic rs1_fwd;
    logic rs2_fwd;
    logic wd_fwd;
    assign rs1_fwd = wb_valid_i & (wb_waddr_i == rs1_raddr_i);
    assign rs2_fwd = wb_valid_i & (wb_waddr_i == rs2_raddr_i);
    assign wd_fwd  = wb_valid_i & (wb_waddr_i == reg_waddr_i);
`else
    logic rs1_fwd;
    logic rs2_fwd;
    logic wd_fwd;
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
    assign wd_fwd  = 1'b0;
`endif

    // x0 is never marked pending, but the address checks keep hits off x0
    // regardless of the scoreboard contents.
    assign rs1_hit = rs1_re_i & (rs1_raddr_i != '0) & sb_q[rs1_raddr_i] & ~rs1_fwd;
    assign rs2_hit = rs2_re_i & (rs2_raddr_i != '0) & sb_q[rs2_raddr_i] & ~rs2_fwd;
    assign raw     = inst_valid_i & (rs1_hit | rs2_hit);
    assign waw     = inst_valid_i & reg_we_i & (reg_waddr_i != '0)
                   & sb_q[reg_waddr_i] & ~wd_fwd;

`ifdef HAZARD_WB_BYPASS_EN
    // A retiring op frees a slot in the same cycle, so the budget is not exhausted.
    assign full = inst_valid_i & is_long_op_i & reg_we_i & (cnt_q == MAX_CNT) & ~wb_valid_i;
`else
    assign full = inst_valid_i & is_long_op_i & reg_we_i & (cnt_q == MAX_CNT);
`endif

    assign flush = jump_flag_i | flush_q;
    assign stall = ~flush & (raw | waw | full | ext_stall_i);
    assign issue = inst_valid_i & ~stall & ~flush;

    // A long op to x0 still occupies a slot until it writes back, so it
    // counts. It never marks the scoreboard.
    assign long_issue = issue & reg_we_i & is_long_op_i;
    assign sb_set     = long_issue & (reg_waddr_i != '0);

    // Saturate at 0 for stray writebacks. Saturate at the budget as a guard.
    assign cnt_dec = wb_valid_i & (cnt_q != 4'd0);
    assign cnt_inc = long_issue & ((cnt_q != MAX_CNT) | cnt_dec);

    always_comb begin
        sb_d = sb_q;
        if (wb_valid_i) begin
            sb_d[wb_waddr_i] = 1'b0;
        end
        // Set after clear: the issuing instruction becomes the new owner.
        if (sb_set) begin
            sb_d[reg_waddr_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q    <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            flush_q <= jump_flag_i;
        end
    end

    always_comb begin
        stall_flag_o           = '0;
        stall_flag_o[CU_STALL] = stall;
        stall_flag_o[CU_FLUSH] = flush;
    end

    assign scoreboard_o  = sb_q;
    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_idu_hazard_ctrl.sv
// tb/tb_idu_hazard_ctrl.sv - self-checking bench for idu_hazard_ctrl

module tb_idu_hazard_ctrl;

`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid_i;
    logic [4:0]  rs1_raddr_i;
    logic        rs1_re_i;
    logic [4:0]  rs2_raddr_i;
    logic        rs2_re_i;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic        is_long_op_i;
    logic        wb_valid_i;
    logic [4:0]  wb_waddr_i;
    logic        jump_flag_i;
    logic        ext_stall_i;
    logic [3:0]  stall_flag_o;
    logic [31:0] scoreboard_o;
    logic [3:0]  outstanding_o;

    idu_hazard_ctrl #(.MAX_OUTSTANDING(4), .CU_BUS_WIDTH(4), .CU_STALL(0), .CU_FLUSH(1)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i),
        .rs1_raddr_i(rs1_raddr_i), .rs1_re_i(rs1_re_i),
        .rs2_raddr_i(rs2_raddr_i), .rs2_re_i(rs2_re_i),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .is_long_op_i(is_long_op_i),
        .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i),
        .jump_flag_i(jump_flag_i), .ext_stall_i(ext_stall_i),
        .stall_flag_o(stall_flag_o), .scoreboard_o(scoreboard_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic iv; logic [4:0] rs1; logic re1; logic [4:0] rs2; logic re2;
        logic we; logic [4:0] wa; logic lng; logic wb; logic [4:0] wba;
        logic jmp; logic ext;
    } stim_t;

    typedef struct packed {
        logic stall; logic flush; logic [31:0] sb; logic [3:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    stim_t tab_s[$];
    exp_t  tab_e[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic stim_t idle();
        return '0;
    endfunction

    function automatic stim_t lng(input int wa);
        stim_t s = '0;
        s.iv = 1'b1; s.we = 1'b1; s.lng = 1'b1; s.wa = 5'(wa);
        return s;
    endfunction

    function automatic stim_t rd1(input int r);
        stim_t s = '0;
        s.iv = 1'b1; s.re1 = 1'b1; s.rs1 = 5'(r);
        return s;
    endfunction

    function automatic exp_t E(input bit st, input bit fl, input logic [31:0] sb, input int cnt);
        exp_t e;
        e.stall = st; e.flush = fl; e.sb = sb; e.cnt = 4'(cnt);
        return e;
    endfunction

    function automatic void add(input stim_t s, input exp_t e);
        tab_s.push_back(s);
        tab_e.push_back(e);
    endfunction

    task automatic apply(input stim_t s);
        inst_valid_i = s.iv;  rs1_raddr_i = s.rs1; rs1_re_i = s.re1;
        rs2_raddr_i  = s.rs2; rs2_re_i    = s.re2; reg_we_i = s.we;
        reg_waddr_i  = s.wa;  is_long_op_i = s.lng; wb_valid_i = s.wb;
        wb_waddr_i   = s.wba; jump_flag_i = s.jmp; ext_stall_i = s.ext;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(idle());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        apply(idle());
        exp_q.push_back(E(0, 0, 32'h0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
            n_fail++;
            $display("FAIL reset: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d",
                     stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_raw();
        stim_t s;
        exp_t  e;
        do_reset();
        add(lng(5), E(0, 0, 32'h0, 0));
        s = rd1(5);
        add(s, E(1, 0, 32'h20, 1));
        add(s, E(1, 0, 32'h20, 1));
        s.wb = 1'b1; s.wba = 5'd5;
        add(s, E(!BYP, 0, 32'h20, 1));
        add(rd1(5), E(0, 0, 32'h0, 0));
        add(idle(), E(0, 0, 32'h0, 0));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL raw[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
    endtask

    task automatic test_full();
        stim_t s;
        exp_t  e;
        do_reset();
        for (int k = 1; k <= 4; k++) add(lng(k), E(0, 0, (32'h1 << k) - 32'h2, k - 1));
        add(lng(6), E(1, 0, 32'h1E, 4));
        add(lng(6), E(1, 0, 32'h1E, 4));
        s = lng(6); s.wb = 1'b1; s.wba = 5'd1;
        add(s, E(!BYP, 0, 32'h1E, 4));
        add(idle(), BYP ? E(0, 0, 32'h5C, 4) : E(0, 0, 32'h1C, 3));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL full[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
    endtask

    task automatic test_flush();
        stim_t s;
        exp_t  e;
        do_reset();
        add(lng(5), E(0, 0, 32'h0, 0));
        add(rd1(5), E(1, 0, 32'h20, 1));
        s = rd1(5); s.we = 1'b1; s.lng = 1'b1; s.wa = 5'd9; s.jmp = 1'b1;
        add(s, E(0, 1, 32'h20, 1));
        s.jmp = 1'b0;
        add(s, E(0, 1, 32'h20, 1));
        add(idle(), E(0, 0, 32'h20, 1));
        s = idle(); s.jmp = 1'b1;
        add(s, E(0, 1, 32'h20, 1));
        add(s, E(0, 1, 32'h20, 1));
        add(idle(), E(0, 1, 32'h20, 1));
        add(idle(), E(0, 0, 32'h20, 1));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL flush[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
    endtask

    task automatic test_same_bit();
        stim_t s;
        exp_t  e;
        do_reset();
        add(lng(8), E(0, 0, 32'h0, 0));
        add(lng(7), E(0, 0, 32'h100, 1));
        s = lng(7); s.wb = 1'b1; s.wba = 5'd7;
        add(s, E(!BYP, 0, 32'h180, 2));
        add(idle(), BYP ? E(0, 0, 32'h180, 2) : E(0, 0, 32'h100, 1));
        add(s, BYP ? E(0, 0, 32'h180, 2) : E(0, 0, 32'h100, 1));
        add(idle(), BYP ? E(0, 0, 32'h180, 2) : E(0, 0, 32'h180, 1));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL same_bit[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
    endtask

    task automatic test_x0_ext();
        stim_t s;
        exp_t  e;
        do_reset();
        add(lng(0), E(0, 0, 32'h0, 0));
        s = rd1(0); s.re2 = 1'b1; s.rs2 = 5'd0; s.we = 1'b1; s.wa = 5'd0;
        add(s, E(0, 0, 32'h0, 1));
        s = idle(); s.iv = 1'b1; s.ext = 1'b1;
        add(s, E(1, 0, 32'h0, 1));
        add(idle(), E(0, 0, 32'h0, 1));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL x0_ext[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
    endtask

    task automatic test_reset_mid();
        stim_t s;
        exp_t  e;
        do_reset();
        add(lng(1), E(0, 0, 32'h0, 0));
        add(lng(2), E(0, 0, 32'h2, 1));
        add(lng(3), E(0, 0, 32'h6, 2));
        add(idle(), E(0, 0, 32'hE, 3));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL reset_mid_pre[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
        // Asynchronous reset between clock edges must clear state immediately.
        #1 rst_n = 1'b0;
        exp_q.push_back(E(0, 0, 32'h0, 0));
        #1 e = exp_q.pop_front();
        n_checks++;
        if (scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
            n_fail++;
            $display("FAIL reset_async: got sb=%h cnt=%0d want sb=%h cnt=%0d",
                     scoreboard_o, outstanding_o, e.sb, e.cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        s = idle(); s.wb = 1'b1; s.wba = 5'd2;
        add(s, E(0, 0, 32'h0, 0));
        add(idle(), E(0, 0, 32'h0, 0));
        foreach (tab_s[i]) begin
            @(posedge clk); #1 apply(tab_s[i]); exp_q.push_back(tab_e[i]);
            @(negedge clk); e = exp_q.pop_front(); n_checks++;
            if (stall_flag_o !== {2'b00, e.flush, e.stall} || scoreboard_o !== e.sb || outstanding_o !== e.cnt) begin
                n_fail++;
                $display("FAIL reset_mid_post[%0d]: got flags=%b sb=%h cnt=%0d want flags=%b sb=%h cnt=%0d", i,
                         stall_flag_o, scoreboard_o, outstanding_o, {2'b00, e.flush, e.stall}, e.sb, e.cnt);
            end
        end
        tab_s.delete(); tab_e.delete();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_full();
        test_flush();
        test_same_bit();
        test_x0_ext();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
